block_loader_288: RTL

Upstream stage of the 288-bit block memory in the double-SHA256 datapath.
- Collects nine 32-bit words from a word-serial valid/ready source (256-bit midstate followed by a 32-bit nonce/tail word).
- Packs them MSW-first into a 288-bit block.
- Issues a single-cycle write strobe to the block memory once that memory reports it is free.
- Holds off the source while a completed block waits to be written.

---
 rtl/block_loader_288.sv | 83 ++++++++
 1 files changed

// File: rtl/block_loader_288.sv
// Packs nine word-serial 32-bit words MSW-first into a 288-bit block and strobes it into the block memory.
// Optional BLOCK_LOADER_BSWAP_EN byte-reverses each accepted word before packing.
`timescale 1ns/1ps
module block_loader_288 #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 9
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clr,
  input  logic [WORD_W-1:0]           word_in,
  input  logic                        word_valid,
  output logic                        word_ready,
  input  logic                        mem_free,
  output logic                        write_en,
  output logic [WORD_W*NUM_WORDS-1:0] block_out,
  output logic [3:0]                  word_count
);

  localparam int BLK_W = WORD_W * NUM_WORDS;
  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  typedef enum logic [1:0] {FILL, PEND, WRITE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic [WORD_W-1:0]  word_ins;

  assign word_ready = (state == FILL);
  // clr wins over a same-cycle handshake, so the word is simply dropped
  assign accept     = word_valid && word_ready && !clr;

  always_comb begin
    word_ins = word_in;
`ifdef BLOCK_LOADER_BSWAP_EN
    for (int b = 0; b < WORD_W/8; b++) begin
      word_ins[8*b +: 8] = word_in[WORD_W-8-8*b +: 8];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (accept && word_count == LAST_IDX) state_nxt = PEND;
        PEND:    if (mem_free) state_nxt = WRITE;
        WRITE:   state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= FILL;
      write_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      write_en <= (state_nxt == WRITE);
    end
  end

  // block_out is left intact after WRITE; the next accept shifts it out
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      block_out  <= '0;
      word_count <= '0;
    end else if (clr) begin
      block_out  <= '0;
      word_count <= '0;
    end else if (accept) begin
      block_out  <= {block_out[BLK_W-WORD_W-1:0], word_ins};
      word_count <= word_count + 4'd1;
    end else if (state == WRITE) begin
      word_count <= '0;
    end
  end

endmodule
